logic_stream_reducer: RTL
=========================

# logic_stream_reducer

Parametrised, clocked successor to the two-input AND example. It accepts a stream of WIDTH-bit operand pairs over a valid/ready handshake and applies a selectable bitwise operation (AND/OR/XOR/XNOR) to each pair. It folds the per-beat results of one packet into a single accumulated word and presents that word with a beat count on a registered valid/ready output. It is the first block in the course sequence with state, backpressure and packet framing.

## Interface
- WIDTH, 8, operand/result width in bits (>=1)
- MAX_LEN, 16, largest packet length counted exactly; longer packets flag overflow
- CNT_W, $clog2(MAX_LEN+1), width of beat count (derived, not overridden)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 XNOR; sampled on first beat of packet only
- in_last  input  1  beat is final beat of packet
- out_valid  output  1  result held, registered
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  accumulated result, registered
- out_count  output  CNT_W  beats in packet, saturating at MAX_LEN
- out_overflow  output  1  packet exceeded MAX_LEN beats

## Operation
- Beat accepted when in_valid && in_ready.
- Per-beat result: r = OP(in_a, in_b), with OP from the latched op.
- States:
  - IDLE: nothing accumulated. On accepted beat: latch op = in_op, acc = r, count = 1. Go to HOLD if in_last, else ACCUM.
  - ACCUM: on accepted beat: acc = OP(acc, r) using latched op; count = min(count+1, MAX_LEN); overflow set if count was already MAX_LEN. Go to HOLD if in_last.
  - HOLD: out_valid=1; out_data/out_count/out_overflow = acc/count/overflow. On out_ready go to IDLE, with out_valid=0 next cycle.
- in_ready = !rst && state != HOLD. There is no bypass: no beat is accepted in the cycle the result is consumed.
- in_op on non-first beats is ignored.
- Overflow is sticky for the packet and clears on entry to IDLE. Accumulation continues past MAX_LEN beats.
- XNOR fold: acc = ~(acc ^ r).
- Reset (any time, including mid-packet or in HOLD): state IDLE, acc 0, count 0, overflow 0, latched op 00. Outputs: out_valid 0, out_data 0, out_count 0, out_overflow 0, in_ready 0 while rst high. A partial packet is discarded and no result is emitted for it.

## Timing
- out_valid rises on the clock edge that accepts the in_last beat, so it is visible the following cycle (latency 1 from last beat).
- Minimum packet period: L beats + 1 HOLD cycle. With out_ready held high, in_ready is low for exactly one cycle between packets.
- While out_valid && !out_ready: out_data, out_count and out_overflow are stable and in_ready is 0.
- out_data, out_count and out_overflow hold their last values in IDLE/ACCUM. They are only meaningful when out_valid=1.
- Single-beat packet (in_last on first beat): out_data = r, out_count = 1.
- in_valid may be asserted without in_last indefinitely. Count saturates at MAX_LEN and never wraps.

## Test plan
All scenarios use WIDTH=8, MAX_LEN=4.
- Single-beat AND: a=F0, b=3C, op=00, last=1, out_ready=1 -> next cycle out_valid=1, out_data=30, out_count=1, out_overflow=0. in_ready is low that cycle and high the cycle after.
- 3-beat XOR: op=10, pairs (01,02), (04,00), (FF,0F), last on third -> per-beat r = 03, 04, F0; out_data=F7, out_count=3.
- Backpressure: complete a 1-beat OR packet (a=81, b=18) with out_ready=0 for 5 cycles while in_valid=1 -> out_valid stays 1, out_data stays 99, in_ready stays 0, no beats consumed. Raise out_ready -> out_valid drops next cycle and the next beat is accepted the cycle after.
- Overflow: 6-beat OR packet, op=01, a = 01, 02, 04, 08, 10, 20, b=00 -> out_data=3F, out_count=4, out_overflow=1. The following 2-beat packet reports overflow=0, count=2.
- Op latched on first beat: beat1 op=00 (a=FF, b=0F), beat2 op=01 (a=F0, b=FF, last) -> AND fold, out_data=00, count=2.
- Async reset mid-packet: 2 beats accepted, rst pulsed between edges -> all outputs 0 immediately, in_ready=0 during rst. After release, single-beat XNOR a=AA, b=0F -> out_data=5A, out_count=1.

Source files
------------

// File: rtl/logic_stream_reducer_if.sv
// Stream bundle for logic_stream_reducer: operand-pair input channel and
// accumulated-result output channel.
interface logic_stream_reducer_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    // Both channels use valid/ready: a transfer happens on a rising clock edge
    // where valid && ready; the sender holds its payload stable while valid is
    // high and ready is low, and valid never waits on ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    // The reducer itself.
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_overflow
    );

    // Producer of operand beats and consumer of results.
    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_overflow
    );
endinterface

// File: rtl/logic_stream_reducer.sv
// Folds the bitwise AND/OR/XOR/XNOR of each operand pair across a packet into
// one word, reported with a saturating beat count and an overflow flag.
module logic_stream_reducer #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    logic_stream_reducer_if.slave  stream,
    output logic [1:0]             dbg_state_o
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       op_q, op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic [1:0]       beat_op;
    logic [WIDTH-1:0] beat_r;
    logic [WIDTH-1:0] fold_r;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] res;
        case (op)
            2'b00:   res = x & y;
            2'b01:   res = x | y;
            2'b10:   res = x ^ y;
            default: res = ~(x ^ y);
        endcase
        return res;
    endfunction

    assign stream.in_ready     = !rst && (state_q != S_HOLD);
    assign stream.out_valid    = out_valid_q;
    assign stream.out_data     = out_data_q;
    assign stream.out_count    = out_count_q;
    assign stream.out_overflow = out_ovf_q;
    assign dbg_state_o         = state_q;

    assign accept = stream.in_valid && (state_q != S_HOLD);

    // The first beat of a packet uses the incoming op; later beats reuse the latched one.
    assign beat_op = (state_q == S_IDLE) ? stream.in_op : op_q;
    assign beat_r  = apply_op(beat_op, stream.in_a, stream.in_b);
    assign fold_r  = apply_op(op_q, acc_q, beat_r);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = stream.in_op;
                    acc_d   = beat_r;
                    count_d = ONE_CNT;
                    ovf_d   = 1'b0;
                    if (stream.in_last) begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = beat_r;
                        out_count_d = ONE_CNT;
                        out_ovf_d   = 1'b0;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end

            S_ACCUM: begin
                if (accept) begin
                    acc_d = fold_r;
                    // Count saturates; any beat beyond MAX_LEN marks the packet overflowed.
                    if (count_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + ONE_CNT;
                    end
                    if (stream.in_last) begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = acc_d;
                        out_count_d = count_d;
                        out_ovf_d   = ovf_d;
                    end
                end
            end

            S_HOLD: begin
                if (stream.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            op_q        <= 2'b00;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule
